// File: rtl/mem_access_stage.sv
// mem_access_stage: OTTER memory-access (M) stage with data-bus FSM and M-to-W register.
// Ports: E-to-M fields in (RegWriteM..MemSignM), StallM out, dmem_* request/response bus,
//        M-to-W register outputs (RegWriteW..PCPlus4W).
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus, suppress
//        the register write and pulse the extra output MisalignW for one W cycle.
//        Without it, low address bits are masked per access size.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemWriteM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [4:0]        RdM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignM,
    output logic              StallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [4:0]        RdW,
`ifdef MISALIGN_TRAP_EN
    output logic              MisalignW,
`endif
    output logic [XLEN-1:0]   PCPlus4W
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_e;

    typedef struct packed {
        logic            regwrite;
        logic [1:0]      resultsrc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc4;
    } w_t;

    state_e state_q, state_d;
    w_t     w_q, w_d;

    logic        is_load;
    logic        is_store;
    logic        mis;
    logic        go;
    logic        gnt_ok;
    logic        rv_ok;
    logic        done;
    logic [1:0]  a_raw;
    logic [1:0]  a;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign a_raw    = ALUResultM[1:0];
    assign is_load  = (ResultSrcM == 2'b01) && !MemWriteM;
    assign is_store = MemWriteM;

    // Offset actually used for lane selection; half/word ignore the low bits
    always_comb begin
        a = a_raw;
        case (MemSizeM)
            2'b00:   a = a_raw;
            2'b01:   a = {a_raw[1], 1'b0};
            default: a = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign mis = (is_load || is_store) &&
                 (((MemSizeM == 2'b01) && a_raw[0]) ||
                  (MemSizeM[1] && (a_raw != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    // go: an access that really uses the bus
    assign go       = (is_load || is_store) && !mis;
    assign dmem_req = !RST && go && (state_q == IDLE);
    assign dmem_we  = dmem_req && is_store;
    assign gnt_ok   = dmem_req && dmem_gnt;
    assign rv_ok    = (state_q == WAIT_R) && dmem_rvalid;
    assign done     = !go || (is_store && gnt_ok) || rv_ok;
    assign StallM   = go && !done;

    assign dmem_addr = {ALUResultM[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM[31:0];
        case (MemSizeM)
            2'b00: begin
                dmem_be    = 4'b0001 << a;
                dmem_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << a;
                dmem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = WriteDataM[31:0];
            end
        endcase
    end

    // MemSignM = 1 selects zero extension
    assign shifted = dmem_rdata >> {a, 3'b000};

    always_comb begin
        ext = shifted;
        case (MemSizeM)
            2'b00:   ext = {{24{!MemSignM && shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{!MemSignM && shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_load && gnt_ok) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A stalled cycle forwards a bubble with every field zeroed
    always_comb begin
        w_d = '0;
        if (done) begin
            w_d.regwrite  = RegWriteM && !mis;
            w_d.resultsrc = ResultSrcM;
            w_d.alu       = ALUResultM;
            w_d.rdata     = rv_ok ? ext : '0;
            w_d.rd        = RdM;
            w_d.pc4       = PCPlus4M;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign mis_d = done && mis;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign MisalignW = mis_q;
`endif

    assign RegWriteW  = w_q.regwrite;
    assign ResultSrcW = w_q.resultsrc;
    assign ALUResultW = w_q.alu;
    assign ReadDataW  = w_q.rdata;
    assign RdW        = w_q.rd;
    assign PCPlus4W   = w_q.pc4;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage.
// Expected W records are queued when an op is driven and checked when it retires.
module tb_mem_access_stage;

    logic        CLK;
    logic        RST;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic [1:0]  MemSizeM;
    logic        MemSignM;
    logic        StallM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [71:0] w;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    mem_access_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .MemSizeM(MemSizeM), .MemSignM(MemSignM), .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
`ifdef MISALIGN_TRAP_EN
        .MisalignW(MisalignW),
`endif
        .PCPlus4W(PCPlus4W)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [1:0] m_off(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) return a;
        if (sz == 2'b01) return a[1] ? 2'd2 : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) return 4'(1 << a);
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_ext(input logic [1:0] sz, input logic sg,
                                          input logic [1:0] a, input logic [31:0] d);
        logic [31:0] s;
        s = d >> (8 * m_off(sz, a));
        if (sz == 2'b00) return sg ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        if (sz == 2'b01) return sg ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return s;
    endfunction

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        RdM        = 5'd0;
        PCPlus4M   = 32'h0;
        MemSizeM   = 2'b00;
        MemSignM   = 1'b0;
        dmem_gnt   = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'hDEADBEEF;
    endtask

    // One M-stage op: gdly cycles without grant, then for loads rdly idle
    // cycles after grant before rvalid.
    task automatic run_op(input logic rw, input logic [1:0] rs, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [1:0] sz, input logic sg,
                          input int gdly, input int rdly, input logic [31:0] rdat,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input string nm);
        logic ld, st, mis;
        logic [31:0] pc4;
        exp_t e, g;
        ld  = (rs == 2'b01) && !mw;
        st  = mw;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (ld || st) && (((sz == 2'b01) && alu[0]) || (sz[1] && (alu[1:0] != 2'b00)));
`endif
        pc4 = $urandom & 32'hFFFF_FFFC;
        e.w      = {rw && !mis, rs, alu, rd, pc4};
        e.rdata  = erd;
        e.chk_rd = ld && !mis;
        e.mis    = mis;
        exp_q.push_back(e);

        @(negedge CLK);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; ALUResultM = alu;
        WriteDataM = wd; RdM = rd; PCPlus4M = pc4; MemSizeM = sz; MemSignM = sg;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;

        if (!(ld || st) || mis) begin
            #1;
            checks++;
            if ({dmem_req, StallM} !== 2'b00) begin
                failures++;
                $display("FAIL %s idle req/stall got=%b want=00", nm, {dmem_req, StallM});
            end
        end else begin
            for (int i = 0; i < gdly; i++) begin
                #1;
                checks++;
                if ({dmem_req, StallM, dmem_we, dmem_addr, dmem_be} !==
                    {1'b1, 1'b1, st, alu[31:2], 2'b00, ebe}) begin
                    failures++;
                    $display("FAIL %s nognt req/stall/we/addr/be got=%h want=%h", nm,
                             {dmem_req, StallM, dmem_we, dmem_addr, dmem_be},
                             {1'b1, 1'b1, st, alu[31:2], 2'b00, ebe});
                end
                @(posedge CLK); #1;
                checks++;
                if (RegWriteW !== 1'b0) begin
                    failures++;
                    $display("FAIL %s bubble RegWriteW got=%b want=0", nm, RegWriteW);
                end
                @(negedge CLK);
            end
            dmem_gnt = 1'b1;
            #1;
            checks++;
            if ({dmem_req, StallM, dmem_we, dmem_addr, dmem_be} !==
                {1'b1, ld, st, alu[31:2], 2'b00, ebe}) begin
                failures++;
                $display("FAIL %s gnt req/stall/we/addr/be got=%h want=%h", nm,
                         {dmem_req, StallM, dmem_we, dmem_addr, dmem_be},
                         {1'b1, ld, st, alu[31:2], 2'b00, ebe});
            end
            if (st) begin
                checks++;
                if (dmem_wdata !== ewd) begin
                    failures++;
                    $display("FAIL %s wdata got=%h want=%h", nm, dmem_wdata, ewd);
                end
            end
            if (ld) begin
                @(posedge CLK); #1;
                dmem_gnt = 1'b0;
                checks++;
                if (RegWriteW !== 1'b0) begin
                    failures++;
                    $display("FAIL %s gnt bubble RegWriteW got=%b want=0", nm, RegWriteW);
                end
                for (int j = 0; j < rdly; j++) begin
                    @(negedge CLK); #1;
                    checks++;
                    if ({dmem_req, StallM} !== 2'b01) begin
                        failures++;
                        $display("FAIL %s wait req/stall got=%b want=01", nm, {dmem_req, StallM});
                    end
                    @(posedge CLK); #1;
                    checks++;
                    if (RegWriteW !== 1'b0) begin
                        failures++;
                        $display("FAIL %s wait bubble got=%b want=0", nm, RegWriteW);
                    end
                end
                @(negedge CLK);
                dmem_rvalid = 1'b1;
                dmem_rdata = rdat;
                #1;
                checks++;
                if (StallM !== 1'b0) begin
                    failures++;
                    $display("FAIL %s rvalid stall got=%b want=0", nm, StallM);
                end
            end
        end

        @(posedge CLK); #1;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'hDEADBEEF;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty got=0 want=1", nm);
        end else begin
            g = exp_q.pop_front();
            if ({RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W} !== g.w) begin
                failures++;
                $display("FAIL %s W fields got=%h want=%h", nm,
                         {RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W}, g.w);
            end
            if (g.chk_rd) begin
                checks++;
                if (ReadDataW !== g.rdata) begin
                    failures++;
                    $display("FAIL %s ReadDataW got=%h want=%h", nm, ReadDataW, g.rdata);
                end
            end
`ifdef MISALIGN_TRAP_EN
            checks++;
            if (MisalignW !== g.mis) begin
                failures++;
                $display("FAIL %s MisalignW got=%b want=%b", nm, MisalignW, g.mis);
            end
`endif
        end
    endtask

    task automatic test_reset();
        drive_nop();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({dmem_req, StallM, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W} !== '0) begin
            failures++;
            $display("FAIL reset outputs got=%h want=0",
                     {dmem_req, StallM, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W});
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_nonmem();
        run_op(1'b1, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5, 2'b10, 1'b0,
               0, 0, 32'h0, 4'b1111, 32'h0, 32'h0, "nonmem");
    endtask

    task automatic test_store();
        run_op(1'b0, 2'b00, 1'b1, 32'h1003, 32'hAABBCCDD, 5'd0, 2'b00, 1'b0,
               0, 0, 32'h0, 4'b1000, 32'hDDDDDDDD, 32'h0, "st_byte");
        run_op(1'b0, 2'b00, 1'b1, 32'h1002, 32'h1111BEEF, 5'd0, 2'b01, 1'b0,
               0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, "st_half");
        run_op(1'b0, 2'b00, 1'b1, 32'h3000, 32'h12345678, 5'd0, 2'b10, 1'b0,
               3, 0, 32'h0, 4'b1111, 32'h12345678, 32'h0, "st_word_wait");
    endtask

    task automatic test_load();
        run_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd7, 2'b00, 1'b0,
               0, 1, 32'h00800000, 4'b0100, 32'h0, 32'hFFFFFF80, "ld_byte_s");
        run_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd7, 2'b00, 1'b1,
               0, 1, 32'h00800000, 4'b0100, 32'h0, 32'h00000080, "ld_byte_u");
        run_op(1'b1, 2'b01, 1'b0, 32'h2004, 32'h0, 5'd9, 2'b10, 1'b0,
               2, 0, 32'hCAFEBABE, 4'b1111, 32'h0, 32'hCAFEBABE, "ld_word");
        run_op(1'b1, 2'b01, 1'b0, 32'h2003, 32'h0, 5'd10, 2'b01, 1'b0,
               0, 0, 32'h80017FFF, 4'b1100, 32'h0, 32'hFFFF8001, "ld_half_odd");
    endtask

    task automatic test_spurious();
        exp_t g;
        @(negedge CLK);
        drive_nop();
        RegWriteM = 1'b1; RdM = 5'd3; ALUResultM = 32'h55; PCPlus4M = 32'h80;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h77777777;
        g.w = {1'b1, 2'b00, 32'h55, 5'd3, 32'h80};
        #1;
        checks++;
        if ({dmem_req, StallM} !== 2'b00) begin
            failures++;
            $display("FAIL spurious req/stall got=%b want=00", {dmem_req, StallM});
        end
        @(posedge CLK); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        checks++;
        if ({RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W} !== g.w) begin
            failures++;
            $display("FAIL spurious W got=%h want=%h",
                     {RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W}, g.w);
        end
        run_op(1'b0, 2'b00, 1'b1, 32'h0010, 32'hA5A5A5A5, 5'd0, 2'b10, 1'b0,
               0, 0, 32'h0, 4'b1111, 32'hA5A5A5A5, 32'h0, "after_spurious");
    endtask

    task automatic test_back_to_back();
        logic [1:0] sz, rs;
        logic mw, sg, rw;
        logic [31:0] alu, wd, rdat;
        int k;
        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            alu = $urandom;
            wd = $urandom;
            rdat = $urandom;
            mw = (k == 1);
            rs = (k == 2) ? 2'b01 : 2'b00;
            rw = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(rw, rs, mw, alu, wd, 5'($urandom_range(1, 31)), sz, sg,
                   $urandom_range(0, 2), $urandom_range(0, 2), rdat,
                   m_be(sz, alu[1:0]), m_wd(sz, wd), m_ext(sz, sg, alu[1:0], rdat), "b2b");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive_nop();
        RegWriteM = 1'b1; ResultSrcM = 2'b01; ALUResultM = 32'h2000;
        RdM = 5'd4; MemSizeM = 2'b10; dmem_gnt = 1'b1;
        @(posedge CLK); #1;
        dmem_gnt = 1'b0;
        checks++;
        if (StallM !== 1'b1) begin
            failures++;
            $display("FAIL rstmid wait stall got=%b want=1", StallM);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL rstmid req during reset got=%b want=0", dmem_req);
        end
        @(posedge CLK); #1;
        checks++;
        if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W} !== '0) begin
            failures++;
            $display("FAIL rstmid W cleared got=%h want=0",
                     {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W});
        end
        @(negedge CLK);
        RST = 1'b0;
        drive_nop();
        MemWriteM = 1'b1; ALUResultM = 32'h40; WriteDataM = 32'h01020304;
        MemSizeM = 2'b10; PCPlus4M = 32'h44;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999;
        #1;
        checks++;
        if ({dmem_req, StallM} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid late rvalid req/stall got=%b want=10", {dmem_req, StallM});
        end
        @(posedge CLK); #1;
        checks++;
        if ({RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W} !==
            {1'b0, 2'b00, 32'h40, 5'd0, 32'h44}) begin
            failures++;
            $display("FAIL rstmid store W got=%h want=%h",
                     {RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W},
                     {1'b0, 2'b00, 32'h40, 5'd0, 32'h44});
        end
        @(negedge CLK);
        drive_nop();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store();
        test_load();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access (M) stage of the pipelined OTTER core. It consumes the E-to-M register outputs and drives the data-memory request/response bus. It generates byte enables and aligned store data, and extracts and extends load data. It stalls the front of the pipe while an access is outstanding, and it contains the M-to-W register feeding writeback.

Parameters:
ADDR_W, 32, data-memory byte-address width
XLEN, 32, datapath width (only 32 supported)

Ports:
CLK  in  1  clock
RST  in  1  reset
RegWriteM  in  1  M-stage register-write enable
ResultSrcM  in  2  result select; 2'b01 = load data
MemWriteM  in  1  store
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data (rs2)
RdM  in  5  destination register
PCPlus4M  in  32  PC+4
MemSizeM  in  2  00 byte, 01 half, 10/11 word
MemSignM  in  1  1 = zero-extend (funct3[2]), 0 = sign-extend
StallM  out  1  hold E-to-M and earlier stages
dmem_req  out  1  bus request
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
RegWriteW, ResultSrcW[1:0], ALUResultW[32], ReadDataW[32], RdW[5], PCPlus4W[32]  out  M-to-W register

Behaviour:
- Reset: one clock, synchronous active-high reset on RST, edge of CLK.
  - State goes to IDLE.
  - All W outputs are cleared to 0.
  - dmem_req is forced 0 while RST is high, even mid-access. Any outstanding rvalid after reset is ignored.
- Access types:
  - load = (ResultSrcM==2'b01) & !MemWriteM
  - store = MemWriteM
  - access = load | store
- FSM:
  - IDLE: if access, dmem_req=1 combinationally.
    - Store with gnt: complete, stay IDLE.
    - Load with gnt: go to WAIT_R.
    - No gnt: stay IDLE. The request stays asserted, and addr/be/wdata stay stable (inputs are held by StallM).
  - WAIT_R: dmem_req=0. On rvalid, complete and go to IDLE. Otherwise hold.
- Completion and stall:
  - done = !access | (store & gnt & IDLE) | (WAIT_R & rvalid)
  - StallM = access & !done (combinational).
- M-to-W register:
  - Each cycle, if done, it captures the M fields.
  - If !done, it captures a bubble: RegWriteW=0, other fields don't-care but driven to 0.
  - Minimum latency: store or non-memory op takes 1 cycle (no stall when gnt is immediate). Load takes at least 2 cycles (1 stall cycle).
- Byte enables (a = ALUResultM[1:0]):
  - byte: 4'b0001<<a
  - half: 4'b0011<<{a[1],1'b0}
  - word: 4'b1111
  - dmem_be is meaningful for both loads and stores.
- wdata:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extract:
  - Shift rdata right by 8*a (half uses {a[1],0}).
  - Take the low 8/16/32 bits, then sign- or zero-extend per MemSignM.
  - Result is captured in ReadDataW on the rvalid cycle.
- Simultaneous events: rvalid arriving in IDLE is ignored. gnt while not requesting is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned = half with a[0]=1, or word with a!=0.
  - A misaligned access issues no bus request and completes in 1 cycle.
  - RegWriteW is forced 0, and an extra output MisalignW (1 bit, reset 0) pulses 1 for that W cycle.
- Undefined:
  - No MisalignW port.
  - Low address bits are masked per size (half ignores a[0], word ignores a[1:0]).
  - The access proceeds normally.

Test Plan:
- Non-memory op, RegWriteM=1, RdM=5, ALUResultM=0x1234 -> no req, StallM=0, next cycle RegWriteW=1, RdW=5, ALUResultW=0x1234.
- Store byte, addr 0x1003, wd 0xAABBCCDD, gnt immediate -> dmem_be=4'b1000, wdata=0xDDDDDDDD, addr=0x1000, StallM=0.
- Store word with gnt low for 3 cycles -> StallM=1 for 3 cycles, req/addr/be stable, W receives bubbles, completes on the gnt cycle.
- Load byte signed, addr 0x2002, rdata 0x00800000, rvalid 2 cycles after gnt -> StallM high until rvalid, ReadDataW=0xFFFFFF80. Same access with MemSignM=1 -> 0x00000080.
- Load half at 0x2003:
  - With MISALIGN_TRAP_EN: no req, MisalignW=1, RegWriteW=0.
  - Without: be=4'b1100, half taken from upper lanes.
- RST asserted in WAIT_R -> next cycle IDLE, W outputs 0, StallM=0. A late rvalid is ignored.
